urna_voting_fsm: RTL and testbench
==================================

Name: urna_voting_fsm

Overview:
- Control FSM of an electronic ballot box. The voter enters a 4-digit BCD candidate code and then confirms the vote.
- On confirmation the block emits exactly one single-cycle pulse on one of five candidate outputs.
- Those pulses directly clock the downstream per-candidate BCD tally counters.
- Sits between the keypad/front panel and the tally counters. Also exposes its state for display and debug.

Parameters:
- CODE_ARTHUR, 16'h1111, BCD code (digito1..digito4, MS digit first) selecting Arthur
- CODE_LEANDRO, 16'h2222, code selecting Leandro
- CODE_MATEUS, 16'h3333, code selecting Mateus
- CODE_PABLO, 16'h4444, code selecting Pablo

Ports:
- clock  in  1  system clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- digit  in  4  BCD digit from keypad
- valid  in  1  digit strobe; digit is accepted on each rising clock edge where valid=1
- confirma  in  1  confirm key
- finish  in  1  closes the election
- estado  out  3  current state register
- next_estado  out  3  combinational next state
- digito1, digito2, digito3, digito4  out  4 each  entered digits, digito1 = first entered
- votoValido  out  1  entered code matches a registered candidate
- candidatoArthur, candidatoLeandro, candidatoMateus, candidatoPablo, candidatoNulo  out  1 each  registered one-cycle vote pulses

Behaviour:
- States: S_DIG1=0, S_DIG2=1, S_DIG3=2, S_DIG4=3, S_CONF=4, S_VOTE=5, S_END=6. Encoding 7 is illegal and goes to S_DIG1 on the next edge.
- Reset (asynchronous, active-high):
  - estado=S_DIG1
  - digito1..4=0
  - all candidate outputs=0
  - Reset mid-operation discards any partial entry; tallies are not affected by this block.
- Input priority each cycle: finish > confirma > valid.
- finish=1 in any state except S_END: next state S_END. This applies even while in S_VOTE; the pulse in progress still completes that cycle.
- S_END is absorbing until reset. All inputs are ignored there and candidate outputs stay 0.
- Digit entry in S_DIGn with valid=1 and digit<=9:
  - store digit into digito<n>
  - advance to the next state (S_DIG4 advances to S_CONF)
- Digit values 10..15 are ignored: no store, no advance.
- confirma in S_DIG1..S_DIG4 is ignored.
- In S_CONF:
  - valid is ignored
  - confirma=1: next state S_VOTE; on that same edge the selected candidate output register is set to 1
- Selection, with code = {digito1,digito2,digito3,digito4}:
  - candidatoArthur if code==CODE_ARTHUR; likewise for Leandro, Mateus and Pablo
  - otherwise candidatoNulo
  - Parameters must be distinct; if codes collide, the first match in the order Arthur, Leandro, Mateus, Pablo wins.
- S_VOTE lasts exactly one cycle:
  - exactly one candidate output is high
  - next edge: all candidate outputs return to 0, digito1..4 clear to 0, state becomes S_DIG1
  - Latency from the confirma edge to the pulse rising is 1 edge; the pulse width is 1 clock.
- Candidate outputs are glitch-free flops, because they drive downstream clocks.
- votoValido is combinational: 1 only when estado∈{S_CONF,S_VOTE} and the code equals one of the four parameters. It is 0 otherwise, including in S_END.
- next_estado reflects the priority rules above.

Optional Feature:
- Macro URNA_CANCEL_EN.
- When defined:
  - adds input cancela (1 bit)
  - in S_DIG1..S_CONF, cancela=1 clears digito1..4 and returns to S_DIG1
  - priority: finish > cancela > confirma > valid
- When undefined: port absent; no cancel path exists and a partial entry can only be cleared by reset.

Test Plan:
- Reset, then digits 1,1,1,1 with valid, then confirma:
  - estado goes 0→1→2→3→4, votoValido=1
  - after confirma, candidatoArthur=1 for exactly one cycle, other candidate outputs 0
  - then estado=0 and digito1..4=0
- Digits 3,3,3,3 then confirma → single candidatoMateus pulse. Digits 9,8,7,6 then confirma → votoValido=0 in S_CONF and a single candidatoNulo pulse.
- Digit 12 with valid in S_DIG2 → no state change, digito2 unchanged. confirma in S_DIG3 → ignored, no pulse.
- finish asserted in S_CONF together with confirma → estado=6, no candidate pulse; further valid/confirma inputs ignored; reset returns estado=0.
- Assert reset asynchronously between clock edges during S_VOTE → candidate output drops immediately, estado=0, digits cleared.
- With URNA_CANCEL_EN: enter 2,2 then cancela → estado=0, digito1=digito2=0; then 2,2,2,2 and confirma → one candidatoLeandro pulse.

Source files
------------

// File: rtl/urna_voting_fsm.sv
// urna_voting_fsm - control FSM of an electronic ballot box.
//
// The voter keys in a 4-digit BCD candidate code and then confirms it. On
// confirmation exactly one registered, single-cycle pulse is produced on one
// of the five candidate outputs; these pulses clock the downstream tally
// counters directly, so they always come straight from flops.
//
// Optional feature: define URNA_CANCEL_EN to add the 'cancela' input, which
// discards a partial entry and returns to the first digit.

module urna_voting_fsm #(
    parameter logic [15:0] CODE_ARTHUR  = 16'h1111,
    parameter logic [15:0] CODE_LEANDRO = 16'h2222,
    parameter logic [15:0] CODE_MATEUS  = 16'h3333,
    parameter logic [15:0] CODE_PABLO   = 16'h4444
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] digit,
    input  logic       valid,
    input  logic       confirma,
    input  logic       finish,
`ifdef URNA_CANCEL_EN
    input  logic       cancela,
`endif
    output logic [2:0] estado,
    output logic [2:0] next_estado,
    output logic [3:0] digito1,
    output logic [3:0] digito2,
    output logic [3:0] digito3,
    output logic [3:0] digito4,
    output logic       votoValido,
    output logic       candidatoArthur,
    output logic       candidatoLeandro,
    output logic       candidatoMateus,
    output logic       candidatoPablo,
    output logic       candidatoNulo
);

    typedef enum logic [2:0] {
        S_DIG1 = 3'd0,
        S_DIG2 = 3'd1,
        S_DIG3 = 3'd2,
        S_DIG4 = 3'd3,
        S_CONF = 3'd4,
        S_VOTE = 3'd5,
        S_END  = 3'd6
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  stateBits;

    logic [3:0]  digit1_q;
    logic [3:0]  digit2_q;
    logic [3:0]  digit3_q;
    logic [3:0]  digit4_q;

    // Candidate pulse flops, ordered {Arthur, Leandro, Mateus, Pablo, Nulo}.
    logic [4:0]  cand_q;
    logic [4:0]  candSel;

    logic [15:0] code;
    logic        matchArthur;
    logic        matchLeandro;
    logic        matchMateus;
    logic        matchPablo;
    logic        codeKnown;

    logic        digitOk;
    logic        cancelReq;
    logic [3:0]  loadEn;
    logic        clearDigits;
    logic        castVote;

`ifdef URNA_CANCEL_EN
    assign cancelReq = cancela;
`else
    assign cancelReq = 1'b0;
`endif

    assign stateBits = state_q;

    // Code comparison against the four registered candidates.
    assign code         = {digit1_q, digit2_q, digit3_q, digit4_q};
    assign matchArthur  = (code == CODE_ARTHUR);
    assign matchLeandro = (code == CODE_LEANDRO);
    assign matchMateus  = (code == CODE_MATEUS);
    assign matchPablo   = (code == CODE_PABLO);
    assign codeKnown    = matchArthur | matchLeandro | matchMateus | matchPablo;

    // Only keypad values 0..9 are real BCD digits; the rest are dropped.
    assign digitOk = valid && (digit <= 4'd9);

    // Candidate selection; if two codes collide the earlier candidate wins.
    always_comb begin
        candSel = 5'b00000;
        if (matchArthur) begin
            candSel = 5'b10000;
        end else if (matchLeandro) begin
            candSel = 5'b01000;
        end else if (matchMateus) begin
            candSel = 5'b00100;
        end else if (matchPablo) begin
            candSel = 5'b00010;
        end else begin
            candSel = 5'b00001;
        end
    end

    // Next-state and datapath control, honouring finish > cancela > confirma > valid.
    always_comb begin
        state_d     = state_q;
        loadEn      = 4'b0000;
        clearDigits = 1'b0;
        castVote    = 1'b0;
        if (state_q == S_END) begin
            state_d = S_END;
        end else if (stateBits == 3'b111) begin
            state_d     = S_DIG1;
            clearDigits = 1'b1;
        end else if (finish) begin
            state_d = S_END;
            if (state_q == S_VOTE) begin
                clearDigits = 1'b1;
            end
        end else if (cancelReq && (state_q != S_VOTE)) begin
            state_d     = S_DIG1;
            clearDigits = 1'b1;
        end else begin
            case (state_q)
                S_DIG1: begin
                    if (digitOk) begin
                        state_d = S_DIG2;
                        loadEn  = 4'b0001;
                    end
                end
                S_DIG2: begin
                    if (digitOk) begin
                        state_d = S_DIG3;
                        loadEn  = 4'b0010;
                    end
                end
                S_DIG3: begin
                    if (digitOk) begin
                        state_d = S_DIG4;
                        loadEn  = 4'b0100;
                    end
                end
                S_DIG4: begin
                    if (digitOk) begin
                        state_d = S_CONF;
                        loadEn  = 4'b1000;
                    end
                end
                S_CONF: begin
                    if (confirma) begin
                        state_d  = S_VOTE;
                        castVote = 1'b1;
                    end
                end
                S_VOTE: begin
                    state_d     = S_DIG1;
                    clearDigits = 1'b1;
                end
                default: begin
                    state_d = S_DIG1;
                end
            endcase
        end
    end

    // State, digit and candidate-pulse registers; pulses default low every cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_DIG1;
            digit1_q <= 4'd0;
            digit2_q <= 4'd0;
            digit3_q <= 4'd0;
            digit4_q <= 4'd0;
            cand_q   <= 5'b00000;
        end else begin
            state_q <= state_d;
            if (clearDigits) begin
                digit1_q <= 4'd0;
                digit2_q <= 4'd0;
                digit3_q <= 4'd0;
                digit4_q <= 4'd0;
            end else begin
                if (loadEn[0]) digit1_q <= digit;
                if (loadEn[1]) digit2_q <= digit;
                if (loadEn[2]) digit3_q <= digit;
                if (loadEn[3]) digit4_q <= digit;
            end
            if (castVote) begin
                cand_q <= candSel;
            end else begin
                cand_q <= 5'b00000;
            end
        end
    end

    assign estado      = state_q;
    assign next_estado = state_d;

    assign digito1 = digit1_q;
    assign digito2 = digit2_q;
    assign digito3 = digit3_q;
    assign digito4 = digit4_q;

    assign votoValido = ((state_q == S_CONF) || (state_q == S_VOTE)) && codeKnown;

    assign candidatoArthur  = cand_q[4];
    assign candidatoLeandro = cand_q[3];
    assign candidatoMateus  = cand_q[2];
    assign candidatoPablo   = cand_q[1];
    assign candidatoNulo    = cand_q[0];

endmodule

// File: tb/tb_urna_voting_fsm.sv
// tb_urna_voting_fsm - directed, self-checking bench for urna_voting_fsm.
// Expected values are hand-computed constants; candidate outputs are compared
// as the vector {Arthur, Leandro, Mateus, Pablo, Nulo}.

module tb_urna_voting_fsm;

    logic       clock;
    logic       reset;
    logic [3:0] digit;
    logic       valid;
    logic       confirma;
    logic       finish;
`ifdef URNA_CANCEL_EN
    logic       cancela;
`endif
    logic [2:0] estado;
    logic [2:0] next_estado;
    logic [3:0] digito1;
    logic [3:0] digito2;
    logic [3:0] digito3;
    logic [3:0] digito4;
    logic       votoValido;
    logic       candidatoArthur;
    logic       candidatoLeandro;
    logic       candidatoMateus;
    logic       candidatoPablo;
    logic       candidatoNulo;

    logic [4:0]  cands;
    logic [15:0] digits;

    int compared;
    int mismatched;

    assign cands  = {candidatoArthur, candidatoLeandro, candidatoMateus, candidatoPablo, candidatoNulo};
    assign digits = {digito1, digito2, digito3, digito4};

    urna_voting_fsm dut (
        .clock            (clock),
        .reset            (reset),
        .digit            (digit),
        .valid            (valid),
        .confirma         (confirma),
        .finish           (finish),
`ifdef URNA_CANCEL_EN
        .cancela          (cancela),
`endif
        .estado           (estado),
        .next_estado      (next_estado),
        .digito1          (digito1),
        .digito2          (digito2),
        .digito3          (digito3),
        .digito4          (digito4),
        .votoValido       (votoValido),
        .candidatoArthur  (candidatoArthur),
        .candidatoLeandro (candidatoLeandro),
        .candidatoMateus  (candidatoMateus),
        .candidatoPablo   (candidatoPablo),
        .candidatoNulo    (candidatoNulo)
    );

    // 10 ns free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance one rising edge and settle 1 ns past it before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one cycle of inputs across a single edge, then return them to idle.
    task automatic applyStimulus(input logic v, input logic [3:0] d,
                                 input logic c, input logic f);
        valid    = v;
        digit    = d;
        confirma = c;
        finish   = f;
        tick();
        valid    = 1'b0;
        digit    = 4'd0;
        confirma = 1'b0;
        finish   = 1'b0;
    endtask

    // Compare one observed value with its expected value.
    task automatic checkOutput(input string tag, input logic [15:0] obs,
                               input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Key in four digits, checking the state after each accepted one.
    task automatic enterCode(input logic [15:0] code, input string tag);
        logic [15:0] c;
        c = code;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, c[15-4*i -: 4], 1'b0, 1'b0);
            checkOutput({tag, "_estado"}, 16'(estado), 16'(i + 1));
        end
    endtask

    // Directed sequence of steps.
    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        digit      = 4'd0;
        valid      = 1'b0;
        confirma   = 1'b0;
        finish     = 1'b0;
`ifdef URNA_CANCEL_EN
        cancela    = 1'b0;
`endif
        $display("[TB] start");

        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_estado", 16'(estado), 16'd0);
        checkOutput("rst_digits", digits, 16'h0000);
        checkOutput("rst_cands", 16'(cands), 16'h00);
        reset = 1'b0;

        // Arthur: 1,1,1,1 then confirm.
        enterCode(16'h1111, "arthur");
        checkOutput("arthur_digits", digits, 16'h1111);
        checkOutput("arthur_valido", 16'(votoValido), 16'd1);
        checkOutput("arthur_next_idle", 16'(next_estado), 16'd4);
        confirma = 1'b1;
        #1;
        checkOutput("arthur_next_conf", 16'(next_estado), 16'd5);
        tick();
        confirma = 1'b0;
        checkOutput("arthur_vote_estado", 16'(estado), 16'd5);
        checkOutput("arthur_pulse", 16'(cands), 16'h10);
        checkOutput("arthur_vote_valido", 16'(votoValido), 16'd1);
        tick();
        checkOutput("arthur_after_estado", 16'(estado), 16'd0);
        checkOutput("arthur_after_cands", 16'(cands), 16'h00);
        checkOutput("arthur_after_digits", digits, 16'h0000);

        // Mateus: 3,3,3,3 then confirm.
        enterCode(16'h3333, "mateus");
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkOutput("mateus_pulse", 16'(cands), 16'h04);
        tick();
        checkOutput("mateus_after_cands", 16'(cands), 16'h00);

        // Null vote: 9,8,7,6.
        enterCode(16'h9876, "nulo");
        checkOutput("nulo_digits", digits, 16'h9876);
        checkOutput("nulo_valido", 16'(votoValido), 16'd0);
        applyStimulus(1'b1, 4'd5, 1'b0, 1'b0);
        checkOutput("nulo_valid_ignored", 16'(estado), 16'd4);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkOutput("nulo_pulse", 16'(cands), 16'h01);
        checkOutput("nulo_vote_valido", 16'(votoValido), 16'd0);
        tick();
        checkOutput("nulo_after_estado", 16'(estado), 16'd0);

        // Illegal digit in S_DIG2, confirm in S_DIG3, then Pablo.
        applyStimulus(1'b1, 4'd4, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd12, 1'b0, 1'b0);
        checkOutput("bad_digit_estado", 16'(estado), 16'd1);
        checkOutput("bad_digit_dig2", 16'(digito2), 16'd0);
        applyStimulus(1'b1, 4'd4, 1'b0, 1'b0);
        checkOutput("dig2_stored", 16'(digito2), 16'd4);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkOutput("conf_in_dig3_estado", 16'(estado), 16'd2);
        checkOutput("conf_in_dig3_cands", 16'(cands), 16'h00);
        applyStimulus(1'b1, 4'd4, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd4, 1'b0, 1'b0);
        checkOutput("pablo_estado", 16'(estado), 16'd4);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkOutput("pablo_pulse", 16'(cands), 16'h02);
        tick();

        // finish together with confirma in S_CONF.
        enterCode(16'h2222, "fin");
        finish   = 1'b1;
        confirma = 1'b1;
        #1;
        checkOutput("fin_next", 16'(next_estado), 16'd6);
        tick();
        finish   = 1'b0;
        confirma = 1'b0;
        checkOutput("fin_estado", 16'(estado), 16'd6);
        checkOutput("fin_cands", 16'(cands), 16'h00);
        checkOutput("fin_valido", 16'(votoValido), 16'd0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkOutput("end_conf_cands", 16'(cands), 16'h00);
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0);
        checkOutput("end_absorb", 16'(estado), 16'd6);
        reset = 1'b1;
        #2;
        checkOutput("end_reset_estado", 16'(estado), 16'd0);
        reset = 1'b0;
        tick();

        // finish during S_VOTE: pulse still completes.
        enterCode(16'h2222, "finvote");
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        finish = 1'b1;
        #1;
        checkOutput("finvote_pulse", 16'(cands), 16'h08);
        checkOutput("finvote_next", 16'(next_estado), 16'd6);
        tick();
        finish = 1'b0;
        checkOutput("finvote_estado", 16'(estado), 16'd6);
        checkOutput("finvote_cands", 16'(cands), 16'h00);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();

        // Asynchronous reset between edges during S_VOTE.
        enterCode(16'h1111, "async");
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkOutput("async_pulse", 16'(cands), 16'h10);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_cands", 16'(cands), 16'h00);
        checkOutput("async_estado", 16'(estado), 16'd0);
        checkOutput("async_digits", digits, 16'h0000);
        reset = 1'b0;
        tick();

`ifdef URNA_CANCEL_EN
        // Cancel a partial entry, then vote Leandro.
        applyStimulus(1'b1, 4'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd2, 1'b0, 1'b0);
        cancela = 1'b1;
        tick();
        cancela = 1'b0;
        checkOutput("cancel_estado", 16'(estado), 16'd0);
        checkOutput("cancel_digits", digits, 16'h0000);
        enterCode(16'h2222, "leandro");
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkOutput("leandro_pulse", 16'(cands), 16'h08);
        tick();
        checkOutput("leandro_after_cands", 16'(cands), 16'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
